// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared constants for the score display: glyph cell geometry, the BCD
// digit limit and the 8x16 bitmaps of the decimal digits 0-9.
// Each bitmap is 16 rows of 8 bits, row 0 in the top byte, and bit 7 of a
// row is the leftmost pixel.
// ---------------------------------------------------------------------------
package score_pkg;

  localparam int         GLYPH_W  = 8;
  localparam int         GLYPH_H  = 16;
  localparam logic [3:0] BCD_NINE = 4'h9;

  localparam logic [127:0] GLYPHS [0:9] = '{
    128'h0000_3C66_666E_7666_6666_6666_3C00_0000,  // 0
    128'h0000_1838_7818_1818_1818_1818_7E00_0000,  // 1
    128'h0000_3C66_0606_0C18_3060_6066_7E00_0000,  // 2
    128'h0000_3C66_0606_1C06_0606_0666_3C00_0000,  // 3
    128'h0000_0C1C_3C6C_CCCC_FE0C_0C0C_1E00_0000,  // 4
    128'h0000_7E60_6060_7C06_0606_0666_3C00_0000,  // 5
    128'h0000_1C30_6060_7C66_6666_6666_3C00_0000,  // 6
    128'h0000_7E66_0606_0C18_1818_1818_1800_0000,  // 7
    128'h0000_3C66_6666_3C66_6666_6666_3C00_0000,  // 8
    128'h0000_3C66_6666_663E_0606_060C_3800_0000   // 9
  };

  // One 8-pixel row of a digit glyph; non-decimal codes give a blank row.
  function automatic logic [7:0] glyph_row(input logic [3:0] digit,
                                           input logic [3:0] row);
    logic [127:0] bmp;
    bmp = '0;
    if (digit <= BCD_NINE) bmp = GLYPHS[digit];
    return bmp[8 * (15 - 32'(row)) +: 8];
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// ---------------------------------------------------------------------------
// digit_glyph_rom
// Combinational glyph lookup shared by every digit of the display.
//   addr : {digit[3:0], row[3:0]}
//   data : glyph row, bit 7 = leftmost pixel; digits 10-15 read as 0
// ---------------------------------------------------------------------------
module digit_glyph_rom
  import score_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] data
);

  always_comb begin
    data = '0;
    if (addr[7:4] <= BCD_NINE) data = glyph_row(addr[7:4], addr[3:0]);
  end

endmodule

// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
// BCD score counter with saturation, frame-latched display register and a
// 2-stage pixel renderer that lights the glyph pixels of the score digits.
//
// Parameters
//   NUM_DIGITS : number of BCD digits (1..8)
//   SCALE      : glyph magnification (1, 2 or 4)
//   ORIGIN_X/Y : top-left pixel of the leftmost digit cell
//   LZ_BLANK   : 1 blanks leading zeros (the last digit always shows)
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous score/overflow clear (beats score_inc)
//   score_inc           : one-cycle pulse, adds one point
//   frame_start         : copies the live score into the display register
//   pix_x, pix_y        : pixel coordinate, qualified by pix_valid
//   score_on            : lit glyph pixel, 2 cycles after the pixel
//   pix_valid_out       : pix_valid aligned with score_on
//   score_bcd           : live score, most significant digit in top nibble
//   overflow            : sticky saturation flag
//   hiscore_bcd         : best score so far
//
// Build option
//   SCORE_DISPLAY_HISCORE_EN : when defined, clear folds the score into a
//   high-score register; otherwise hiscore_bcd is tied to 0.
// ---------------------------------------------------------------------------
module score_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCALE      = 1,
  parameter int ORIGIN_X   = 0,
  parameter int ORIGIN_Y   = 0,
  parameter int LZ_BLANK   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    score_inc,
  input  logic                    frame_start,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    pix_valid,
  output logic                    score_on,
  output logic                    pix_valid_out,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow,
  output logic [4*NUM_DIGITS-1:0] hiscore_bcd
);

  localparam int SW    = 4 * NUM_DIGITS;
  localparam int SHIFT = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_W * SCALE);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + GLYPH_H * SCALE);

  // Add one with decimal ripple carry; the caller handles the all-nines case.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (v[4*k +: 4] == BCD_NINE) begin
          r[4*k +: 4] = 4'h0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [SW-1:0] score;
  logic [SW-1:0] disp;
  logic          all_nines;

  assign all_nines = (score == {NUM_DIGITS{BCD_NINE}});
  assign score_bcd = score;

  // Score counter and display register; disp takes the value from before
  // any same-cycle increment or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score    <= '0;
      overflow <= 1'b0;
      disp     <= '0;
    end else begin
      if (frame_start) disp <= score;
      if (clear) begin
        score    <= '0;
        overflow <= 1'b0;
      end else if (score_inc) begin
        if (all_nines) overflow <= 1'b1;
        else           score    <= bcd_inc(score);
      end
    end
  end

`ifdef SCORE_DISPLAY_HISCORE_EN
  logic [SW-1:0] hiscore;

  // Packed BCD orders like binary, so a plain unsigned compare is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore <= '0;
    end else if (clear && (score > hiscore)) begin
      hiscore <= score;
    end
  end

  assign hiscore_bcd = hiscore;
`else
  assign hiscore_bcd = '0;
`endif

  // Stage 0: region test and glyph coordinates, shifts only
  logic [10:0] px, py, dx, dy, dxs, dys;
  logic        in_region;
  logic        unused_bits;

  assign px        = {1'b0, pix_x};
  assign py        = {1'b0, pix_y};
  assign in_region = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
  assign dx        = px - X_LO;
  assign dy        = py - Y_LO;
  assign dxs       = dx >> SHIFT;
  assign dys       = dy >> SHIFT;
  // High bits only matter outside the region, where in_region masks them.
  assign unused_bits = ^{dxs[10:6], dys[10:4]};

  // Stage 1 registers
  logic       in_region_p1;
  logic       vld_p1;
  logic [2:0] digit_idx_p1;
  logic [2:0] col_p1;
  logic [3:0] row_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_region_p1 <= 1'b0;
      vld_p1       <= 1'b0;
      digit_idx_p1 <= '0;
      col_p1       <= '0;
      row_p1       <= '0;
    end else begin
      in_region_p1 <= in_region;
      vld_p1       <= pix_valid;
      digit_idx_p1 <= dxs[5:3];
      col_p1       <= dxs[2:0];
      row_p1       <= dys[3:0];
    end
  end

  // Digit select from the display register plus leading-zero detection:
  // a digit is a leading zero when it and every digit to its left are 0.
  logic [3:0] sel_digit;
  logic       lead_zero;
  logic       zero_run;

  always_comb begin
    sel_digit = '0;
    lead_zero = 1'b0;
    zero_run  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (disp[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      if (digit_idx_p1 == 3'(k)) begin
        sel_digit = disp[4*(NUM_DIGITS-1-k) +: 4];
        lead_zero = zero_run && (k != NUM_DIGITS - 1);
      end
    end
  end

  logic [7:0] rom_data;
  logic       rom_bit;
  logic       blank;

  digit_glyph_rom u_rom (
    .addr ({sel_digit, row_p1}),
    .data (rom_data)
  );

  assign rom_bit = rom_data[3'd7 - col_p1];
  assign blank   = (LZ_BLANK != 0) && lead_zero;

  // Stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_on      <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      score_on      <= vld_p1 && in_region_p1 && rom_bit && !blank;
      pix_valid_out <= vld_p1;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// ---------------------------------------------------------------------------
// tb_score_display
// Bench for score_display (NUM_DIGITS=4, SCALE=2, ORIGIN=(16,16)); one
// instance with leading-zero blanking off and one with it on, sharing
// stimulus. Expected values come from a decimal-integer score model and a
// coordinate-arithmetic pixel model.
// ---------------------------------------------------------------------------
module tb_score_display;
  import score_pkg::*;

  localparam int ND = 4;
`ifdef SCORE_DISPLAY_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clear, score_inc, frame_start, pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic        on0, on1, pvo0, pvo1, ovf0, ovf1;
  logic [15:0] sc0, sc1, hi0, hi1;

  always #5 clk = ~clk;

  score_display #(.NUM_DIGITS(ND), .SCALE(2), .ORIGIN_X(16), .ORIGIN_Y(16), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .score_inc(score_inc),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .score_on(on0), .pix_valid_out(pvo0), .score_bcd(sc0), .overflow(ovf0),
    .hiscore_bcd(hi0));

  score_display #(.NUM_DIGITS(ND), .SCALE(2), .ORIGIN_X(16), .ORIGIN_Y(16), .LZ_BLANK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .score_inc(score_inc),
    .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .score_on(on1), .pix_valid_out(pvo1), .score_bcd(sc1), .overflow(ovf1),
    .hiscore_bcd(hi1));

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_score, m_disp, m_hi;
  bit m_ovf;
  int s1_x, s1_y;
  bit s1_v;
  bit e_on0, e_on1, e_pvo;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int k = 0; k < ND; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit pix_model(input int x, input int y, input bit v,
                                   input int disp, input bit lz);
    int k, col, row, d, pw;
    logic [7:0] g;
    if (!v) return 1'b0;
    if (x < 16 || x >= 16 + ND * 16 || y < 16 || y >= 48) return 1'b0;
    k   = (x - 16) / 16;
    col = ((x - 16) % 16) / 2;
    row = (y - 16) / 2;
    pw  = 1;
    for (int i = 0; i < ND - 1 - k; i++) pw = pw * 10;
    d = (disp / pw) % 10;
    if (lz && k < ND - 1 && disp < pw) return 1'b0;
    g = glyph_row(4'(d), 4'(row));
    return g[7 - col];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score = 0; m_disp = 0; m_hi = 0; m_ovf = 1'b0;
    s1_x = 0; s1_y = 0; s1_v = 1'b0;
    e_on0 = 1'b0; e_on1 = 1'b0; e_pvo = 1'b0;
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance the model at
  // the edge and return at the next posedge+1.
  task automatic tick(input bit c, input bit i, input bit f,
                      input int x, input int y, input bit v);
    clear = c; score_inc = i; frame_start = f;
    pix_x = 10'(x); pix_y = 10'(y); pix_valid = v;
    @(posedge clk);
    e_on0 = pix_model(s1_x, s1_y, s1_v, m_disp, 1'b0);
    e_on1 = pix_model(s1_x, s1_y, s1_v, m_disp, 1'b1);
    e_pvo = s1_v;
    s1_x = x; s1_y = y; s1_v = v;
    if (f) m_disp = m_score;
    if (c) begin
      if (HI_EN && m_score > m_hi) m_hi = m_score;
      m_score = 0;
      m_ovf   = 1'b0;
    end else if (i) begin
      if (m_score == 9999) m_ovf = 1'b1;
      else                 m_score++;
    end
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".score0"}, 32'(sc0), 32'(to_bcd(m_score)));
    chk({tag, ".score1"}, 32'(sc1), 32'(to_bcd(m_score)));
    chk({tag, ".ovf"},    32'(ovf0), 32'(m_ovf));
    chk({tag, ".hi"},     32'(hi0), 32'(to_bcd(m_hi)));
    chk({tag, ".on0"},    32'(on0), 32'(e_on0));
    chk({tag, ".on1"},    32'(on1), 32'(e_on1));
    chk({tag, ".pvo0"},   32'(pvo0), 32'(e_pvo));
    chk({tag, ".pvo1"},   32'(pvo1), 32'(e_pvo));
  endtask

  task automatic set_score(input int t);
    if (t < m_score) tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    while (m_score < t) tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  typedef struct {
    int score;
    int x;
    int y;
    bit v;
    bit e0;
    bit e1;
  } pix_vec_t;

  pix_vec_t vecs [12];

  initial begin
    vecs[0]  = '{1,   70, 20, 1'b1, 1'b1, 1'b1};  // LSD '1' lit
    vecs[1]  = '{1,   64, 20, 1'b1, 1'b0, 1'b0};  // LSD '1' unlit column
    vecs[2]  = '{1,   20, 20, 1'b1, 1'b1, 1'b0};  // leading zero
    vecs[3]  = '{1,   70, 20, 1'b0, 1'b0, 1'b0};  // invalid pixel
    vecs[4]  = '{1,   15, 20, 1'b1, 1'b0, 1'b0};  // left of region
    vecs[5]  = '{1,   70, 48, 1'b1, 1'b0, 1'b0};  // below region
    vecs[6]  = '{42,  20, 20, 1'b1, 1'b1, 1'b0};  // leading zero, 0042
    vecs[7]  = '{42,  48, 32, 1'b1, 1'b1, 1'b1};  // '4' row 8 col 0
    vecs[8]  = '{42,  80, 20, 1'b1, 1'b0, 1'b0};  // right of region
    vecs[9]  = '{42,  36, 20, 1'b1, 1'b1, 1'b0};  // second leading zero
    vecs[10] = '{100, 52, 20, 1'b1, 1'b1, 1'b1};  // embedded zero renders
    vecs[11] = '{100, 20, 20, 1'b1, 1'b1, 1'b0};  // leading zero, 0100

    // Reset state
    rst_n = 1'b0; clear = 1'b0; score_inc = 1'b0; frame_start = 1'b0;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    idle();

    // Ten increments carry into the tens digit
    repeat (10) tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("inc10.score", 32'(sc0), 32'h0010);
    chk("inc10.ovf", 32'(ovf0), 32'h0);
    check_all("inc10");

    // Pixel vectors: latch, present, then check exact 2-cycle latency
    for (int n = 0; n < 12; n++) begin
      set_score(vecs[n].score);
      tick(1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, vecs[n].x, vecs[n].y, vecs[n].v);
      chk($sformatf("vec%0d.lat1", n), 32'(on0 | on1), 32'h0);
      idle();
      chk($sformatf("vec%0d.on0", n), 32'(on0), 32'(vecs[n].e0));
      chk($sformatf("vec%0d.on1", n), 32'(on1), 32'(vecs[n].e1));
      chk($sformatf("vec%0d.pvo", n), 32'(pvo0), 32'(vecs[n].v));
    end

    // High score
    set_score(150);
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("hi150", 32'(hi0), HI_EN ? 32'h0150 : 32'h0);
    chk("hi150.score", 32'(sc0), 32'h0);
    set_score(20);
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("hi20", 32'(hi0), HI_EN ? 32'h0150 : 32'h0);
    chk("hi20.lz", 32'(hi1), HI_EN ? 32'h0150 : 32'h0);

    // frame_start with score_inc latches the pre-increment value (7, not 8)
    set_score(7);
    tick(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 68, 28, 1'b1);
    idle();
    chk("fs_inc.on", 32'(on0), 32'h0);
    chk("fs_inc.score", 32'(sc0), 32'h0008);
    check_all("fs_inc");

    // Saturation at all nines, then clear beats score_inc
    set_score(9999);
    chk("sat.pre", 32'(sc0), 32'h9999);
    chk("sat.pre_ovf", 32'(ovf0), 32'h0);
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("sat.score", 32'(sc0), 32'h9999);
    chk("sat.ovf", 32'(ovf0), 32'h1);
    idle();
    chk("sat.sticky", 32'(ovf1), 32'h1);
    tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    chk("clr.score", 32'(sc0), 32'h0);
    chk("clr.ovf", 32'(ovf0), 32'h0);
    check_all("clr");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      tick(($urandom_range(199) == 0), $urandom_range(1), ($urandom_range(7) == 0),
           int'($urandom_range(99)), int'($urandom_range(59)), ($urandom_range(3) != 0));
      check_all($sformatf("rnd%0d", n));
    end

    // Asynchronous reset with pixels in flight
    set_score(3);
    tick(1'b0, 1'b0, 1'b1, 70, 20, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 70, 20, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 70, 20, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.score", 32'(sc0), 32'h0);
    chk("arst.ovf", 32'(ovf0 | ovf1), 32'h0);
    chk("arst.hi", 32'(hi0), 32'h0);
    chk("arst.on", 32'(on0 | on1), 32'h0);
    chk("arst.pvo", 32'(pvo0 | pvo1), 32'h0);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 1'b0, 70, 20, 1'b1);
    check_all("post_rst1");
    chk("post_rst1.on", 32'(on0), 32'h0);
    idle();
    check_all("post_rst2");
    chk("post_rst2.on", 32'(on0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound the whole run
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
